code_patch_rd_tracker: RTL and testbench



---
 rtl/code_patch_pkg.sv | 12 +
 rtl/code_patch_rd_fifo.sv | 41 ++++
 rtl/code_patch_rd_tracker.sv | 79 +++++++
 tb/tb_code_patch_rd_tracker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/code_patch_pkg.sv
// code_patch_pkg: shared types and widths for the code-patch read tracker
package code_patch_pkg;
  localparam int IDX_FIELD_W = 8;
  typedef struct packed {
    logic                   is_read;
    logic                   match;
    logic [IDX_FIELD_W-1:0] idx;
  } rd_entry_t;
  function automatic int patch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/code_patch_rd_fifo.sv
// code_patch_rd_fifo: synchronous FIFO with occupancy count, pointers wrap modulo DEPTH
module code_patch_rd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // storage needs no reset: entries are only read while counted
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rptr_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/code_patch_rd_tracker.sv
// code_patch_rd_tracker: in-order bus transaction tracker producing per-response read/patch-match qualifiers
module code_patch_rd_tracker
  import code_patch_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int NUM_PATCH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   bus_req_i,
  input  logic                                   bus_gnt_i,
  input  logic                                   bus_we_i,
  input  logic [ADDR_W-1:0]                      bus_addr_i,
  input  logic                                   bus_rvalid_i,
  input  logic [NUM_PATCH-1:0][ADDR_W-1:0]       patch_addr_i,
  input  logic [NUM_PATCH-1:0]                   patch_en_i,
  input  logic                                   err_clr_i,
  output logic                                   req_block_o,
  output logic                                   si_read_o,
  output logic                                   match_o,
  output logic [patch_idx_w(NUM_PATCH)-1:0]      match_idx_o,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
  output logic                                   err_o
);
  localparam int IW = patch_idx_w(NUM_PATCH);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  logic                   accept, pop, push, full, empty, hit, err_q, err_d, block_q, block_d;
  logic [IDX_FIELD_W-1:0] hit_idx;
  logic [CW-1:0]          count, count_nxt;
  rd_entry_t              push_e, head_e;
  assign accept = bus_req_i & bus_gnt_i;
  assign pop    = bus_rvalid_i & ~empty;
  assign push   = accept & (~full | pop);
  // word-address priority match, lowest enabled slot wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_PATCH - 1; k >= 0; k--)
      if (patch_en_i[k] && ((patch_addr_i[k] ^ bus_addr_i) & ~ADDR_W'(3)) == '0) begin
        hit     = 1'b1;
        hit_idx = IDX_FIELD_W'(k);
      end
  end
  assign push_e = '{is_read: ~bus_we_i, match: ~bus_we_i & hit, idx: bus_we_i ? '0 : hit_idx};
  code_patch_rd_fifo #(.W($bits(rd_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_e),
    .rdata_o (head_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign si_read_o     = pop & head_e.is_read;
  assign match_o       = pop & head_e.is_read & head_e.match;
  assign match_idx_o   = match_o ? IW'(head_e.idx) : '0;
  assign outstanding_o = count;
  assign err_o         = err_q;
  assign req_block_o   = block_q;
  assign count_nxt     = count + CW'(push) - CW'(pop);
  // sticky error wins over a same-cycle clear; block tracks the post-update count
  always_comb begin
    err_d   = ((bus_rvalid_i & empty) | (accept & full & ~pop)) ? 1'b1 : err_clr_i ? 1'b0 : err_q;
    block_d = count_nxt == CW'(MAX_OUTSTANDING);
  end
  // error and back-pressure registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      block_q <= block_d;
    end
  end
endmodule

// File: tb/tb_code_patch_rd_tracker.sv
// tb_code_patch_rd_tracker: directed self-checking bench for the read tracker
module tb_code_patch_rd_tracker;
  logic             clk_i = 1'b0, rst_ni = 1'b0;
  logic             bus_req_i = 1'b0, bus_gnt_i = 1'b0, bus_we_i = 1'b0, bus_rvalid_i = 1'b0, err_clr_i = 1'b0;
  logic [31:0]      bus_addr_i = '0;
  logic [3:0][31:0] patch_addr_i = '0;
  logic [3:0]       patch_en_i = '0;
  logic             req_block_o, si_read_o, match_o, err_o;
  logic [1:0]       match_idx_o;
  logic [2:0]       outstanding_o;
  int               n_tests = 0, n_fail = 0;
  code_patch_rd_tracker #(.ADDR_W(32), .NUM_PATCH(4), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus_req_i(bus_req_i), .bus_gnt_i(bus_gnt_i), .bus_we_i(bus_we_i),
    .bus_addr_i(bus_addr_i), .bus_rvalid_i(bus_rvalid_i), .patch_addr_i(patch_addr_i), .patch_en_i(patch_en_i),
    .err_clr_i(err_clr_i), .req_block_o(req_block_o), .si_read_o(si_read_o), .match_o(match_o),
    .match_idx_o(match_idx_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic acc, input logic we, input logic [31:0] addr, input logic rv, input logic clr);
    bus_req_i = acc; bus_gnt_i = acc; bus_we_i = we; bus_addr_i = addr; bus_rvalid_i = rv; err_clr_i = clr;
    #1;
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic resp(input string tag, input logic sr, input logic m, input logic [1:0] idx);
    chk({tag, "_si_read"}, 32'(si_read_o), 32'(sr));
    chk({tag, "_match"}, 32'(match_o), 32'(m));
    chk({tag, "_idx"}, 32'(match_idx_o), 32'(idx));
  endtask
  initial begin
    #2;
    chk("rst_outstanding", 32'(outstanding_o), 0);
    chk("rst_block", 32'(req_block_o), 0);
    chk("rst_err", 32'(err_o), 0);
    resp("rst", 0, 0, 0);
    #10 rst_ni = 1'b1;
    tick();
    // single matching read, response two cycles after grant
    patch_addr_i[1] = 32'h1000; patch_en_i = 4'b0010;
    bus(1, 0, 32'h1000, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t1_outstanding", 32'(outstanding_o), 1);
    resp("t1_gap", 0, 0, 0);
    tick();
    bus(0, 0, 0, 1, 0);
    resp("t1_rsp", 1, 1, 1);
    tick();
    bus(0, 0, 0, 0, 0);
    resp("t1_after", 0, 0, 0);
    chk("t1_outstanding_end", 32'(outstanding_o), 0);
    // lowest slot wins on duplicate addresses; writes never match
    patch_addr_i[0] = 32'h2000; patch_addr_i[2] = 32'h2000; patch_en_i = 4'b0101;
    bus(1, 0, 32'h2002, 0, 0); tick();
    bus(1, 1, 32'h2000, 0, 0); tick();
    bus(0, 0, 0, 1, 0);
    resp("t2_rd", 1, 1, 0);
    tick();
    resp("t2_wr", 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t2_outstanding", 32'(outstanding_o), 0);
    chk("t2_err", 32'(err_o), 0);
    // fill the FIFO with mixed match results
    patch_addr_i[0] = 32'h2000; patch_addr_i[1] = 32'h1000; patch_en_i = 4'b0011;
    bus(1, 0, 32'h1000, 0, 0); tick();
    bus(1, 0, 32'h3000, 0, 0); tick();
    bus(1, 0, 32'h2004, 0, 0); tick();
    chk("t3_count3", 32'(outstanding_o), 3);
    chk("t3_block3", 32'(req_block_o), 0);
    bus(1, 0, 32'h2000, 0, 0); tick();
    bus(0, 0, 0, 0, 0);
    chk("t3_count4", 32'(outstanding_o), 4);
    chk("t3_block4", 32'(req_block_o), 1);
    chk("t3_err_full", 32'(err_o), 0);
    // overflow grant is dropped and flagged
    bus(1, 0, 32'h1000, 0, 0); tick();
    bus(0, 0, 0, 0, 0);
    chk("t3_overflow_count", 32'(outstanding_o), 4);
    chk("t3_overflow_err", 32'(err_o), 1);
    bus(0, 0, 0, 0, 1); tick();
    bus(0, 0, 0, 0, 0);
    chk("t3_err_clr", 32'(err_o), 0);
    // accept and pop together while full
    bus(1, 0, 32'h1000, 1, 0);
    resp("t4_head", 1, 1, 1);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t4_count", 32'(outstanding_o), 4);
    chk("t4_err", 32'(err_o), 0);
    chk("t4_block", 32'(req_block_o), 1);
    // patch state changes after grant must not affect queued results
    patch_en_i = 4'b0000; patch_addr_i[1] = 32'h0;
    bus(0, 0, 0, 1, 0);
    resp("t5_e1", 1, 0, 0);
    tick();
    chk("t5_count3", 32'(outstanding_o), 3);
    chk("t5_block_rel", 32'(req_block_o), 0);
    resp("t5_e2", 1, 0, 0);
    tick();
    resp("t5_e3", 1, 1, 0);
    tick();
    resp("t5_e4_wrapped", 1, 1, 1);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t5_count0", 32'(outstanding_o), 0);
    chk("t5_err", 32'(err_o), 0);
    // response with nothing outstanding
    bus(0, 0, 0, 1, 0);
    resp("t6_empty", 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t6_err", 32'(err_o), 1);
    chk("t6_count", 32'(outstanding_o), 0);
    bus(0, 0, 0, 1, 1); tick();
    bus(0, 0, 0, 0, 0);
    chk("t6_set_beats_clr", 32'(err_o), 1);
    bus(0, 0, 0, 0, 1); tick();
    bus(0, 0, 0, 0, 0);
    chk("t6_clr", 32'(err_o), 0);
    // grant and response in the same cycle while empty
    bus(1, 0, 32'h5000, 1, 0);
    resp("t7_same", 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t7_count", 32'(outstanding_o), 1);
    chk("t7_err", 32'(err_o), 1);
    bus(0, 0, 0, 0, 1); tick();
    bus(1, 0, 32'h5000, 0, 0); tick();
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t7_count3", 32'(outstanding_o), 3);
    // async reset mid-operation discards everything at once
    bus(0, 0, 0, 1, 0);
    rst_ni = 1'b0;
    #1;
    chk("t8_rst_count", 32'(outstanding_o), 0);
    chk("t8_rst_err", 32'(err_o), 0);
    chk("t8_rst_block", 32'(req_block_o), 0);
    resp("t8_rst", 0, 0, 0);
    bus(0, 0, 0, 0, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    bus(0, 0, 0, 1, 0);
    resp("t8_post", 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0);
    chk("t8_post_err", 32'(err_o), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
